// File: rtl/pixel_plane_serializer.sv
// Bit-plane serializer: shadows NUM_PLANES plane words on an accepted start and emits them one per
// accepted beat, LSB-plane-first or MSB-plane-first, with back-to-back frames and no bubble.
module pixel_plane_serializer #(
  parameter int unsigned DATA_W     = 128,
  parameter int unsigned NUM_PLANES = 19,
  parameter int unsigned IDX_W      = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         msb_first,
  input  logic [NUM_PLANES*DATA_W-1:0] din,
  output logic                         start_rdy,
  output logic [DATA_W-1:0]            dout,
  output logic                         oe,
  input  logic                         dout_ready,
  output logic [IDX_W-1:0]             plane_idx,
  output logic                         last,
  output logic                         busy
);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_PLANES - 1);
  localparam logic [IDX_W-1:0] OneIdx  = IDX_W'(1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               order_q, order_d;
  logic               last_q, last_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic [DATA_W-1:0]  shadow_q [NUM_PLANES];

  logic               accept, beat;
  logic [IDX_W-1:0]   first_idx, next_idx;
  logic [DATA_W-1:0]  first_word;
  logic               next_last;

  assign oe        = (state_q == StShift);
  assign busy      = oe;
  assign dout      = dout_q;
  assign plane_idx = idx_q;
  assign last      = last_q;
  assign start_rdy = ~oe | (oe & dout_ready & last_q);
  assign accept    = start & start_rdy;
  assign beat      = oe & dout_ready;

  // The first plane comes straight from din since the shadow loads on the same edge.
  assign first_idx  = msb_first ? LastIdx : '0;
  assign first_word = msb_first ? din[NUM_PLANES*DATA_W-1 -: DATA_W] : din[DATA_W-1:0];
  assign next_idx   = order_q ? (idx_q - OneIdx) : (idx_q + OneIdx);
  assign next_last  = order_q ? (next_idx == '0) : (next_idx == LastIdx);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    order_d = order_q;
    last_d  = last_q;
    dout_d  = dout_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StShift;
          order_d = msb_first;
          idx_d   = first_idx;
          dout_d  = first_word;
          last_d  = 1'b0;
        end
      end
      StShift: begin
        if (beat) begin
          if (last_q && accept) begin
            order_d = msb_first;
            idx_d   = first_idx;
            dout_d  = first_word;
            last_d  = 1'b0;
          end else if (last_q) begin
            state_d = StIdle;
            idx_d   = '0;
            dout_d  = '0;
            last_d  = 1'b0;
          end else begin
            idx_d  = next_idx;
            dout_d = shadow_q[next_idx];
            last_d = next_last;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      order_q <= 1'b0;
      last_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      order_q <= order_d;
      last_q  <= last_d;
      dout_q  <= dout_d;
    end
  end

  // Shadow is data-only and deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < int'(NUM_PLANES); k++) begin
        shadow_q[k] <= din[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_pixel_plane_serializer.sv
// Scoreboard bench for pixel_plane_serializer: expected beats are queued on accepted starts and
// compared against every cycle's outputs.
module tb_pixel_plane_serializer;

  localparam int DW = 8;
  localparam int NP = 19;
  localparam int IW = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             msb_first;
  logic [NP*DW-1:0] din;
  logic             start_rdy;
  logic [DW-1:0]    dout;
  logic             oe;
  logic             dout_ready;
  logic [IW-1:0]    plane_idx;
  logic             last;
  logic             busy;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [IW-1:0] i;
    logic          l;
  } beat_t;

  beat_t q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_beats  = 0;
  int    n_accept = 0;

  pixel_plane_serializer #(.DATA_W(DW), .NUM_PLANES(NP), .IDX_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .msb_first  (msb_first),
    .din        (din),
    .start_rdy  (start_rdy),
    .dout       (dout),
    .oe         (oe),
    .dout_ready (dout_ready),
    .plane_idx  (plane_idx),
    .last       (last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_din(input logic [7:0] base);
    for (int k = 0; k < NP; k++) din[k*DW +: DW] = 8'(base + 8'(k));
  endtask

  // Model: outputs checked each negedge, beat popped, and a new frame queued on a modelled accept.
  always @(negedge clk) begin
    logic exp_oe, exp_rdy;
    beat_t b;
    if (!rst) begin
      exp_oe  = (q.size() != 0);
      exp_rdy = !exp_oe || (dout_ready && q[0].l);
      check("oe", 32'(oe), 32'(exp_oe));
      check("busy", 32'(busy), 32'(exp_oe));
      check("start_rdy", 32'(start_rdy), 32'(exp_rdy));
      if (exp_oe) begin
        check("dout", 32'(dout), 32'(q[0].d));
        check("plane_idx", 32'(plane_idx), 32'(q[0].i));
        check("last", 32'(last), 32'(q[0].l));
        if (dout_ready) begin
          void'(q.pop_front());
          n_beats++;
        end
      end else begin
        check("dout_idle", 32'(dout), 32'd0);
        check("idx_idle", 32'(plane_idx), 32'd0);
        check("last_idle", 32'(last), 32'd0);
      end
      if (start && exp_rdy) begin
        n_accept++;
        for (int k = 0; k < NP; k++) begin
          int p;
          p   = msb_first ? (NP - 1 - k) : k;
          b.d = din[p*DW +: DW];
          b.i = IW'(p);
          b.l = (k == NP - 1);
          q.push_back(b);
        end
      end
    end
  end

  task automatic wait_size(input int remaining, input string tag);
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      if (q.size() == remaining) return;
    end
    check({tag, "_timeout"}, 32'(q.size()), 32'(remaining));
  endtask

  task automatic send(input logic [7:0] base, input logic msb);
    set_din(base);
    msb_first = msb;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    int beats0;
    rst        = 1'b1;
    start      = 1'b0;
    msb_first  = 1'b0;
    dout_ready = 1'b1;
    din        = '0;
    #1;
    check("rst_oe", 32'(oe), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_idx", 32'(plane_idx), 32'd0);
    check("rst_last", 32'(last), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // LSB order
    beats0 = n_beats;
    send(8'hA0, 1'b0);
    wait_size(0, "lsb");
    repeat (3) @(posedge clk);
    #1;
    check("lsb_beats", 32'(n_beats - beats0), 32'(NP));

    // MSB order
    beats0 = n_beats;
    send(8'hA0, 1'b1);
    wait_size(0, "msb");
    repeat (3) @(posedge clk);
    #1;
    check("msb_beats", 32'(n_beats - beats0), 32'(NP));

    // Backpressure at plane 5
    beats0 = n_beats;
    send(8'hA0, 1'b0);
    wait_size(NP - 5, "bp");
    dout_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    dout_ready = 1'b1;
    wait_size(0, "bp_drain");
    repeat (3) @(posedge clk);
    #1;
    check("bp_beats", 32'(n_beats - beats0), 32'(NP));

    // Back-to-back: start held, din/order changed mid-frame
    beats0 = n_accept;
    set_din(8'hA0);
    msb_first = 1'b0;
    start     = 1'b1;
    @(posedge clk);
    #1;
    set_din(8'h10);
    msb_first = 1'b1;
    for (int c = 0; c < 100 && n_accept < beats0 + 2; c++) begin
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check("b2b_accepts", 32'(n_accept - beats0), 32'd2);
    wait_size(0, "b2b_drain");
    repeat (3) @(posedge clk);
    #1;

    // Ignored start at beat 7
    beats0 = n_beats;
    send(8'hA0, 1'b0);
    wait_size(NP - 7, "ign");
    set_din(8'h40);
    msb_first = 1'b1;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_size(0, "ign_drain");
    repeat (4) @(posedge clk);
    #1;
    check("ign_beats", 32'(n_beats - beats0), 32'(NP));

    // Reset at beat 10
    send(8'hA0, 1'b0);
    wait_size(NP - 10, "rst_mid");
    rst = 1'b1;
    #1;
    check("mid_rst_oe", 32'(oe), 32'd0);
    check("mid_rst_dout", 32'(dout), 32'd0);
    check("mid_rst_idx", 32'(plane_idx), 32'd0);
    check("mid_rst_last", 32'(last), 32'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Recovery frame after reset
    beats0 = n_beats;
    send(8'h30, 1'b1);
    wait_size(0, "recov");
    repeat (3) @(posedge clk);
    #1;
    check("recov_beats", 32'(n_beats - beats0), 32'(NP));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
